// File: rtl/swb_cfg_seq_pkg.sv
// rtl/swb_cfg_seq_pkg.sv - request kinds, opcodes, commit fields and FSM states for the switchbox config sequencer
package swb_cfg_seq_pkg;

  localparam int PAYLOAD_WIDTH = 24;
  localparam int KIND_WIDTH    = 2;

  typedef enum logic [1:0] {
    KIND_SWB     = 2'd0,
    KIND_ROUTE   = 2'd1,
    KIND_COMMIT  = 2'd2,
    KIND_ILLEGAL = 2'd3
  } req_kind_e;

  localparam logic [2:0] OPCODE_SWB   = 3'b100;
  localparam logic [2:0] OPCODE_ROUTE = 3'b101;

  typedef struct packed {
    logic [6:0] delay;
    logic [3:0] mask;
  } commit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DELAY,
    ST_ACTIVATE
  } seq_state_e;

  // Only the low 11 payload bits carry commit information; the rest are ignored.
  function automatic commit_t unpack_commit(input logic [10:0] field);
    commit_t c;
    c.delay = field[10:4];
    c.mask  = field[3:0];
    return c;
  endfunction

endpackage

// File: rtl/swb_cfg_seq_fifo.sv
// rtl/swb_cfg_seq_fifo.sv - synchronous request FIFO with registered-state full/empty flags
module swb_cfg_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rptr[AW-1:0]];
  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/swb_cfg_sequencer.sv
// rtl/swb_cfg_sequencer.sv - buffers config requests and serializes them onto the switchbox instr/activate port
// Define SWB_CFG_SEQ_STATS_EN to add saturating instr/commit pulse counters.
module swb_cfg_sequencer
  import swb_cfg_seq_pkg::*;
#(
  parameter int FIFO_DEPTH           = 4,
  parameter int RESOURCE_INSTR_WIDTH = 27,
  parameter int FSM_PER_SLOT         = 4,
  parameter int DELAY_WIDTH          = 7
) (
  input  logic                            clk_0,
  input  logic                            rst_0,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [1:0]                      req_kind,
  input  logic [23:0]                     req_payload,
  output logic                            instr_en_0,
  output logic [RESOURCE_INSTR_WIDTH-1:0] instr_0,
  output logic [FSM_PER_SLOT-1:0]         activate_0,
  output logic                            busy,
  output logic                            commit_done,
  output logic                            err
`ifdef SWB_CFG_SEQ_STATS_EN
  ,
  output logic [15:0]                     stat_instr_cnt,
  output logic [15:0]                     stat_commit_cnt
`endif
);

  localparam int ENTRY_WIDTH = KIND_WIDTH + PAYLOAD_WIDTH;

  seq_state_e                      r_state, w_state_nxt;
  logic                            r_live;
  logic                            r_instr_en, w_en_nxt;
  logic [RESOURCE_INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic [FSM_PER_SLOT-1:0]         r_act, w_act_nxt;
  logic                            r_done, w_done_nxt;
  logic                            r_err, w_err_nxt;
  logic [DELAY_WIDTH-1:0]          r_cnt, w_cnt_nxt;
  logic [FSM_PER_SLOT-1:0]         r_mask, w_mask_nxt;

  logic                            w_push, w_pop, w_full, w_empty;
  logic [ENTRY_WIDTH-1:0]          w_head;
  req_kind_e                       w_head_kind;
  logic [PAYLOAD_WIDTH-1:0]        w_head_payload;
  commit_t                         w_commit;

  swb_cfg_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .i_clk       (clk_0),
    .i_rst       (rst_0),
    .i_push      (w_push),
    .i_push_data ({req_kind, req_payload}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // r_live keeps ready low until the first cycle after reset is released.
  assign req_ready      = r_live & ~w_full;
  assign w_push         = req_valid & req_ready;
  assign w_head_kind    = req_kind_e'(w_head[ENTRY_WIDTH-1 -: KIND_WIDTH]);
  assign w_head_payload = w_head[PAYLOAD_WIDTH-1:0];
  assign w_commit       = unpack_commit(w_head_payload[10:0]);
  assign busy           = ~w_empty | (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_en_nxt    = 1'b0;
    w_instr_nxt = r_instr;
    w_act_nxt   = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    case (r_state)
      ST_IDLE, ST_ISSUE: begin
        w_state_nxt = ST_IDLE;
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head_kind)
            KIND_SWB: begin
              w_en_nxt    = 1'b1;
              w_instr_nxt = {OPCODE_SWB, w_head_payload};
              w_state_nxt = ST_ISSUE;
            end
            KIND_ROUTE: begin
              w_en_nxt    = 1'b1;
              w_instr_nxt = {OPCODE_ROUTE, w_head_payload};
              w_state_nxt = ST_ISSUE;
            end
            KIND_COMMIT: begin
              w_cnt_nxt  = w_commit.delay;
              w_mask_nxt = w_commit.mask;
              if (w_commit.delay != '0) begin
                w_state_nxt = ST_DELAY;
              end else begin
                w_state_nxt = ST_ACTIVATE;
                w_act_nxt   = w_commit.mask;
                w_done_nxt  = 1'b1;
              end
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      ST_DELAY: begin
        w_cnt_nxt = r_cnt - DELAY_WIDTH'(1);
        if (r_cnt == DELAY_WIDTH'(1)) begin
          w_state_nxt = ST_ACTIVATE;
          w_act_nxt   = r_mask;
          w_done_nxt  = 1'b1;
        end
      end
      // Nothing is popped here so the next instruction never overlaps the activate pulse.
      ST_ACTIVATE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      r_state    <= ST_IDLE;
      r_live     <= 1'b0;
      r_instr_en <= 1'b0;
      r_instr    <= '0;
      r_act      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_mask     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_live     <= 1'b1;
      r_instr_en <= w_en_nxt;
      r_instr    <= w_instr_nxt;
      r_act      <= w_act_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mask     <= w_mask_nxt;
    end
  end

  assign instr_en_0  = r_instr_en;
  assign instr_0     = r_instr;
  assign activate_0  = r_act;
  assign commit_done = r_done;
  assign err         = r_err;

`ifdef SWB_CFG_SEQ_STATS_EN
  logic [15:0] r_stat_instr;
  logic [15:0] r_stat_commit;

  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      r_stat_instr  <= '0;
      r_stat_commit <= '0;
    end else begin
      if (w_en_nxt && (r_stat_instr != 16'hFFFF))    r_stat_instr  <= r_stat_instr + 16'd1;
      if (w_done_nxt && (r_stat_commit != 16'hFFFF)) r_stat_commit <= r_stat_commit + 16'd1;
    end
  end

  assign stat_instr_cnt  = r_stat_instr;
  assign stat_commit_cnt = r_stat_commit;
`endif

endmodule

// File: tb/tb_swb_cfg_sequencer.sv
// tb/tb_swb_cfg_sequencer.sv - self-checking bench for swb_cfg_sequencer with a request-level timing model
module tb_swb_cfg_sequencer;

  logic        clk_0 = 1'b0;
  logic        rst_0;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [23:0] req_payload;
  logic        instr_en_0;
  logic [26:0] instr_0;
  logic [3:0]  activate_0;
  logic        busy;
  logic        commit_done;
  logic        err;
`ifdef SWB_CFG_SEQ_STATS_EN
  logic [15:0] stat_instr_cnt;
  logic [15:0] stat_commit_cnt;
`endif

  swb_cfg_sequencer dut (
    .clk_0       (clk_0),
    .rst_0       (rst_0),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_payload (req_payload),
    .instr_en_0  (instr_en_0),
    .instr_0     (instr_0),
    .activate_0  (activate_0),
    .busy        (busy),
    .commit_done (commit_done),
    .err         (err)
`ifdef SWB_CFG_SEQ_STATS_EN
    ,
    .stat_instr_cnt  (stat_instr_cnt),
    .stat_commit_cnt (stat_commit_cnt)
`endif
  );

  always #5 clk_0 = ~clk_0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        en;
    logic [26:0] instr;
    logic [3:0]  act;
    logic        done;
    logic        err;
    logic        rdy;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [1:0]  kind;
    logic [23:0] pl;
    int          gap;
  } stim_t;

  obs_t  obs[$];
  stim_t stim[$];
  stim_t accd[$];
  int    acc_at[$];
  int    m_pop[$];
  int    m_evt[$];

  task automatic do_reset();
    req_valid   = 1'b0;
    req_kind    = 2'd0;
    req_payload = 24'd0;
    rst_0       = 1'b1;
    @(negedge clk_0);
    @(negedge clk_0);
    rst_0 = 1'b0;
    obs.delete();
    stim.delete();
    accd.delete();
    acc_at.delete();
  endtask

  // Entry r of obs holds the outputs during cycle r; a request driven at r is accepted at r if ready.
  task automatic run_stim(input int ncyc);
    for (int r = 0; r < ncyc; r++) begin
      @(negedge clk_0);
      obs.push_back({instr_en_0, instr_0, activate_0, commit_done, err, req_ready, busy});
      req_valid = 1'b0;
      if (stim.size() != 0) begin
        if (stim[0].gap > 0) begin
          stim[0].gap = stim[0].gap - 1;
        end else begin
          req_valid   = 1'b1;
          req_kind    = stim[0].kind;
          req_payload = stim[0].pl;
          if (req_ready) begin
            acc_at.push_back(r);
            accd.push_back(stim.pop_front());
          end
        end
      end
    end
    @(posedge clk_0);
    #1 req_valid = 1'b0;
  endtask

  // Requests are served one at a time: a request starts the cycle after it lands or once
  // the previous one frees the sequencer; a commit adds its delay plus a dead cycle.
  function automatic void build_model();
    int free_t;
    int p;
    int d;
    free_t = 0;
    m_pop.delete();
    m_evt.delete();
    foreach (accd[i]) begin
      p = (acc_at[i] + 1 > free_t) ? acc_at[i] + 1 : free_t;
      d = (accd[i].kind == 2'd2) ? int'(accd[i].pl[10:4]) : 0;
      m_pop.push_back(p);
      m_evt.push_back(p + 1 + d);
      free_t = p + 1 + d + ((accd[i].kind == 2'd2) ? 1 : 0);
    end
  endfunction

  function automatic obs_t model_at(input int k);
    obs_t m;
    int   occ;
    logic active;
    m      = '0;
    occ    = 0;
    active = 1'b0;
    foreach (accd[i]) begin
      if (acc_at[i] + 1 <= k && k <= m_pop[i]) occ++;
      case (accd[i].kind)
        2'd0, 2'd1: begin
          if (m_evt[i] <= k) m.instr = {(accd[i].kind == 2'd0) ? 3'b100 : 3'b101, accd[i].pl};
          if (m_evt[i] == k) begin
            m.en   = 1'b1;
            active = 1'b1;
          end
        end
        2'd2: begin
          if (m_evt[i] == k) begin
            m.act  = accd[i].pl[3:0];
            m.done = 1'b1;
          end
          if (m_pop[i] + 1 <= k && k <= m_evt[i]) active = 1'b1;
        end
        default: if (m_evt[i] == k) m.err = 1'b1;
      endcase
    end
    m.rdy  = (occ < 4);
    m.busy = (occ > 0) || active;
    return m;
  endfunction

  task automatic test_reset();
    rst_0     = 1'b1;
    req_valid = 1'b1;
    req_kind  = 2'd0;
    req_payload = 24'h123456;
    @(negedge clk_0);
    @(negedge clk_0);
    n_cmp++; if ({instr_en_0, commit_done, err, busy} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {instr_en_0, commit_done, err, busy}); end
    n_cmp++; if (instr_0 !== 27'd0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr_0); end
    n_cmp++; if (activate_0 !== 4'd0) begin n_bad++; $display("FAIL reset_act: got %h want 0", activate_0); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_reset: got %b want 0", req_ready); end
    rst_0     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk_0);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    stim.push_back('{2'd0, 24'h4AC400, 0});
    run_stim(6);
    n_cmp++; if (obs[1].en !== 1'b0) begin n_bad++; $display("FAIL single_early_en: got %b want 0", obs[1].en); end
    n_cmp++; if (obs[2].en !== 1'b1) begin n_bad++; $display("FAIL single_en: got %b want 1", obs[2].en); end
    n_cmp++; if (obs[2].instr !== 27'h44AC400) begin n_bad++; $display("FAIL single_instr: got %h want 44ac400", obs[2].instr); end
    n_cmp++; if (obs[3].en !== 1'b0) begin n_bad++; $display("FAIL single_en_width: got %b want 0", obs[3].en); end
    n_cmp++; if (obs[3].busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", obs[3].busy); end
    n_cmp++; if (obs[4].instr !== 27'h44AC400) begin n_bad++; $display("FAIL single_hold: got %h want 44ac400", obs[4].instr); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pl [5];
    do_reset();
    stim.push_back('{2'd2, 24'h0000AF, 0});
    for (int j = 0; j < 5; j++) begin
      pl[j] = 24'hA50000 | 24'(j * 24'h111);
      stim.push_back('{2'd1, pl[j], 0});
    end
    run_stim(25);
    n_cmp++; if (obs[4].rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_before_full: got %b want 1", obs[4].rdy); end
    n_cmp++; if (obs[5].rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b want 0", obs[5].rdy); end
    n_cmp++; if (obs[13].rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_pop_cycle: got %b want 0", obs[13].rdy); end
    n_cmp++; if (obs[14].rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", obs[14].rdy); end
    n_cmp++; if ({obs[12].act, obs[12].done, obs[12].en} !== 6'b1111_1_0) begin n_bad++; $display("FAIL b2b_activate: got %b want 111110", {obs[12].act, obs[12].done, obs[12].en}); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if ({obs[14+j].en, obs[14+j].instr} !== {1'b1, 3'b101, pl[j]}) begin n_bad++; $display("FAIL b2b_instr%0d: got %b/%h want 1/%h", j, obs[14+j].en, obs[14+j].instr, {3'b101, pl[j]}); end
    end
    n_cmp++; if (obs[19].en !== 1'b0) begin n_bad++; $display("FAIL b2b_tail: got %b want 0", obs[19].en); end
  endtask

  task automatic test_commit();
    do_reset();
    stim.push_back('{2'd0, 24'h123456, 0});
    stim.push_back('{2'd2, 24'h000035, 0});
    run_stim(10);
    n_cmp++; if (obs[2].en !== 1'b1) begin n_bad++; $display("FAIL commit_issue: got %b want 1", obs[2].en); end
    n_cmp++; if ({obs[5].act, obs[5].done} !== 5'd0) begin n_bad++; $display("FAIL commit_early: got %b want 0", {obs[5].act, obs[5].done}); end
    n_cmp++; if ({obs[6].act, obs[6].done, obs[6].en} !== 6'b0101_1_0) begin n_bad++; $display("FAIL commit_pulse: got %b want 010110", {obs[6].act, obs[6].done, obs[6].en}); end
    n_cmp++; if ({obs[7].act, obs[7].done} !== 5'd0) begin n_bad++; $display("FAIL commit_width: got %b want 0", {obs[7].act, obs[7].done}); end
    n_cmp++; if (obs[7].busy !== 1'b0) begin n_bad++; $display("FAIL commit_idle: got %b want 0", obs[7].busy); end
  endtask

  task automatic test_commit_zero();
    do_reset();
    stim.push_back('{2'd0, 24'h000001, 0});
    stim.push_back('{2'd2, 24'hFFF800, 0});
    stim.push_back('{2'd0, 24'h000002, 0});
    run_stim(8);
    n_cmp++; if ({obs[3].act, obs[3].done} !== 5'b0000_1) begin n_bad++; $display("FAIL zero_pulse: got %b want 00001", {obs[3].act, obs[3].done}); end
    n_cmp++; if ({obs[3].en, obs[4].en, obs[4].done} !== 3'b000) begin n_bad++; $display("FAIL zero_no_overlap: got %b want 000", {obs[3].en, obs[4].en, obs[4].done}); end
    n_cmp++; if ({obs[5].en, obs[5].instr} !== {1'b1, 27'h4000002}) begin n_bad++; $display("FAIL zero_next_instr: got %b/%h want 1/4000002", obs[5].en, obs[5].instr); end
  endtask

  task automatic test_illegal();
    int n_en;
    int n_err;
    do_reset();
    stim.push_back('{2'd0, 24'h0000AA, 0});
    stim.push_back('{2'd3, 24'hFFFFFF, 0});
    stim.push_back('{2'd0, 24'h0000BB, 0});
    run_stim(8);
    n_en  = 0;
    n_err = 0;
    foreach (obs[k]) begin
      n_en  += int'(obs[k].en);
      n_err += int'(obs[k].err);
    end
    n_cmp++; if ({obs[3].err, obs[3].en} !== 2'b10) begin n_bad++; $display("FAIL illegal_err: got %b want 10", {obs[3].err, obs[3].en}); end
    n_cmp++; if ({obs[4].en, obs[4].instr} !== {1'b1, 27'h40000BB}) begin n_bad++; $display("FAIL illegal_second: got %b/%h want 1/40000bb", obs[4].en, obs[4].instr); end
    n_cmp++; if (n_en !== 2) begin n_bad++; $display("FAIL illegal_instr_count: got %0d want 2", n_en); end
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL illegal_err_count: got %0d want 1", n_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.push_back('{2'd2, 24'h00014F, 0});
    stim.push_back('{2'd0, 24'h000011, 0});
    stim.push_back('{2'd0, 24'h000022, 0});
    run_stim(8);
    n_cmp++; if ({obs[7].busy, obs[7].en, obs[7].done} !== 3'b100) begin n_bad++; $display("FAIL midrst_in_delay: got %b want 100", {obs[7].busy, obs[7].en, obs[7].done}); end
    rst_0 = 1'b1;
    @(posedge clk_0);
    @(negedge clk_0);
    n_cmp++; if ({instr_en_0, instr_0, activate_0, commit_done, err, req_ready, busy} !== 36'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", {instr_en_0, instr_0, activate_0, commit_done, err, req_ready, busy}); end
    rst_0 = 1'b0;
    obs.delete();
    run_stim(30);
    foreach (obs[k]) begin
      n_cmp++; if (obs[k] !== obs_t'({34'd0, 1'b1, 1'b0})) begin n_bad++; $display("FAIL midrst_quiet%0d: got %h want idle", k, obs[k]); end
    end
  endtask

  task automatic test_random();
    int    u;
    int    n_i;
    int    n_c;
    obs_t  m;
    logic [23:0] pl;
    logic [1:0]  kd;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      u  = int'($urandom_range(0, 9));
      kd = (u < 4) ? 2'd0 : (u < 7) ? 2'd1 : (u < 9) ? 2'd2 : 2'd3;
      pl = 24'($urandom);
      if (kd == 2'd2) pl[10:4] = 7'($urandom_range(0, 12));
      stim.push_back('{kd, pl, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0});
    end
    run_stim(900);
    n_cmp++; if (stim.size() !== 0) begin n_bad++; $display("FAIL rand_drain: got %0d left want 0", stim.size()); end
    build_model();
    foreach (obs[k]) begin
      m = model_at(k);
      n_cmp++; if (obs[k] !== m) begin n_bad++; $display("FAIL rand_cycle%0d: got %h want %h", k, obs[k], m); end
    end
    n_i = 0;
    n_c = 0;
    foreach (accd[i]) begin
      if (accd[i].kind == 2'd0 || accd[i].kind == 2'd1) n_i++;
      if (accd[i].kind == 2'd2) n_c++;
    end
`ifdef SWB_CFG_SEQ_STATS_EN
    n_cmp++; if (stat_instr_cnt !== 16'(n_i)) begin n_bad++; $display("FAIL stat_instr: got %0d want %0d", stat_instr_cnt, n_i); end
    n_cmp++; if (stat_commit_cnt !== 16'(n_c)) begin n_bad++; $display("FAIL stat_commit: got %0d want %0d", stat_commit_cnt, n_c); end
    rst_0 = 1'b1;
    @(posedge clk_0);
    @(negedge clk_0);
    rst_0 = 1'b0;
    n_cmp++; if ({stat_instr_cnt, stat_commit_cnt} !== 32'd0) begin n_bad++; $display("FAIL stat_clear: got %h want 0", {stat_instr_cnt, stat_commit_cnt}); end
`else
    n_cmp++; if (accd.size() !== n_i + n_c + (60 - n_i - n_c)) begin n_bad++; $display("FAIL rand_accept_count: got %0d want 60", accd.size()); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_commit();
    test_commit_zero();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
